hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
// - Sequences the 5-stage pipeline around the execute stage: forwarding selects for ALU operands, load-use stalls,
//   branch/jump flushes, and multi-cycle execute ops (start/done handshake with an iterative unit).
// - Sits beside the F/D/E/M/W pipeline registers and drives their stall/flush enables.
// - Keeps saturating stall/flush performance counters.
// PARAMETERS
// - MC_TIMEOUT  64  max cycles in MC_WAIT before mc_error is raised and the op is abandoned
// - CNT_W       16  width of the performance counters (saturating)
// PORTS
// - clk          in   1   clock, rising edge
// - rst          in   1   synchronous, active-high reset
// - Rs1D, Rs2D   in   5   source registers of the instruction in decode
// - Rs1E, Rs2E   in   5   source registers of the instruction in execute
// - RdE, RdM, RdW in  5   destination registers in E/M/W
// - RegWriteM, RegWriteW in 1  write enables in M/W
// - ResultSrcE   in   2   2'b01 = load in execute
// - PCSrcE       in   1   taken branch/jump resolved in execute
// - McOpE        in   1   instruction in execute is multi-cycle
// - mc_done      in   1   iterative unit result valid (1-cycle pulse)
// - ForwardAE, ForwardBE out 2  00 = RD1E/RD2E, 10 = ALUResultM, 01 = ResultW
// - StallF, StallD, StallE out 1  hold the PC / IF-ID / ID-EX registers
// - FlushD, FlushE, FlushM out 1  bubble into IF-ID / ID-EX / EX-MEM
// - mc_start     out  1   1-cycle start pulse to the iterative unit
// - mc_error     out  1   sticky; set on timeout, cleared only by rst
// - stall_cnt, flush_cnt out CNT_W  saturating performance counters
// BEHAVIOUR
// - Reset: state=RUN; every output 0; counters 0; timer 0.
// - Forwarding (combinational, all states): per operand X in {1,2}: if RsXE!=0 && RegWriteM && RsXE==RdM -> 10;
//   else if RsXE!=0 && RegWriteW && RsXE==RdW -> 01; else 00. M has priority over W.
// - lduse = ResultSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
// - FSM states RUN, MC_WAIT, MC_DRAIN:
//   RUN: PCSrcE=1 -> FlushD=FlushE=1 for that cycle, no stalls (the flush takes priority over lduse).
//        Else McOpE=1 -> mc_start=1 in that same cycle, StallF=StallD=StallE=1, FlushM=1; next state MC_WAIT, timer=0.
//        Else lduse -> StallF=StallD=1, FlushE=1 for exactly one cycle. Else all enables 0.
//   MC_WAIT: StallF=StallD=StallE=1, FlushM=1, timer++. PCSrcE and lduse are ignored.
//        mc_done=1 -> MC_DRAIN. timer==MC_TIMEOUT-1 without done -> mc_error=1, FlushE=1, -> RUN.
//   MC_DRAIN: one cycle with all stalls/flushes 0, so the result enters EX-MEM. mc_start is never asserted here.
//        Next state RUN. A back-to-back McOpE is seen in RUN on the next cycle.
// - mc_done outside MC_WAIT: ignored. mc_done in the same cycle as the timeout: done wins, no error.
// - Latency: one MC op of N cycles costs N+1 stall cycles; lduse costs 1; a taken branch costs 2 flushed slots.
// - stall_cnt += 1 on every cycle with StallF=1; flush_cnt += 1 on every cycle with FlushD|FlushE|FlushM=1.
//   Both saturate at all-ones and never wrap.
// - rst mid-MC_WAIT: returns to RUN next edge, mc_start is not re-issued, counters are cleared.
// STRUCTURE
// - Shared package hazard_pkg: fwd_sel_t enum {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}; hc_state_t enum;
//   RESULTSRC_LOAD=2'b01 constant.
// - One sub-module: forward_unit (pure combinational ForwardAE/ForwardBE), instantiated once.
// - FSM, timer and counters live in hazard_controller.
// TESTING
// - Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; then RegWriteM=0 -> 01;
//   Rs1E=0 -> 00.
// - Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle; stall_cnt=1.
// - Branch + lduse: PCSrcE=1 with the same lduse hit -> FlushD=FlushE=1, StallF=0; flush_cnt=1.
// - MC op: McOpE=1, mc_done pulses 4 cycles after mc_start -> one mc_start pulse, stalls held 5 cycles,
//   then a 1-cycle MC_DRAIN, then RUN.
// - Timeout: MC_TIMEOUT=8, mc_done never arrives -> mc_error=1 after 8 cycles, FlushE=1, state RUN, mc_error sticky.
// - Reset in MC_WAIT, plus counter saturation: CNT_W=4 with 20 lduse stalls -> stall_cnt=15;
//   rst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    // Operand source selected by the forwarding muxes in execute.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // RUN: normal flow; MC_WAIT: iterative unit busy; MC_DRAIN: result moves to EX-MEM.
    typedef enum logic [1:0] {
        HC_RUN      = 2'b00,
        HC_MC_WAIT  = 2'b01,
        HC_MC_DRAIN = 2'b10
    } hc_state_t;

    // ResultSrc encoding that marks a load in execute.
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // A producer can only hand a value to a consumer when it targets a real (non-x0) register.
    function automatic logic regMatch(input logic [4:0] rs, input logic [4:0] rd);
        return (rd != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle of pipeline-facing signals exchanged with the hazard controller.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             McOpE;
    logic             mc_done;

    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             mc_start;
    logic             mc_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // The pipeline side drives register ids and control, and consumes the enables.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McOpE, mc_done,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, mc_start, mc_error, stall_cnt, flush_cnt
    );

    // The controller side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McOpE, mc_done,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, mc_start, mc_error, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/forward_unit.sv
// Combinational ALU operand forwarding selects for the execute stage.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs1E,
    input  logic [4:0] i_rs2E,
    input  logic [4:0] i_rdM,
    input  logic [4:0] i_rdW,
    input  logic       i_regWriteM,
    input  logic       i_regWriteW,
    output fwd_sel_t   o_forwardAE,
    output fwd_sel_t   o_forwardBE
);

    // Memory stage holds the younger value, so it wins over writeback.
    function automatic fwd_sel_t selectSource(
        input logic [4:0] rsE,
        input logic [4:0] rdM,
        input logic [4:0] rdW,
        input logic       regWriteM,
        input logic       regWriteW
    );
        if (regWriteM && regMatch(rsE, rdM)) begin
            return FWD_M;
        end else if (regWriteW && regMatch(rsE, rdW)) begin
            return FWD_W;
        end else begin
            return FWD_RF;
        end
    endfunction

    // Pick the source of each ALU operand independently.
    always_comb begin
        o_forwardAE = selectSource(i_rs1E, i_rdM, i_rdW, i_regWriteM, i_regWriteW);
        o_forwardBE = selectSource(i_rs2E, i_rdM, i_rdW, i_regWriteM, i_regWriteW);
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stalls, branch flushes,
// multi-cycle execute sequencing and saturating stall/flush counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  bus
);

    // The timer never needs to exceed MC_TIMEOUT-1 before the op is abandoned.
    localparam int TIMER_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;

    hc_state_t          r_state;
    hc_state_t          w_nextState;
    logic [TIMER_W-1:0] r_timer;
    logic               r_mcError;
    logic [CNT_W-1:0]   r_stallCnt;
    logic [CNT_W-1:0]   r_flushCnt;

    fwd_sel_t           w_fwdA;
    fwd_sel_t           w_fwdB;
    logic               w_lduse;
    logic               w_timerExpired;
    logic               w_abandon;
    logic               w_stallF;
    logic               w_stallD;
    logic               w_stallE;
    logic               w_flushD;
    logic               w_flushE;
    logic               w_flushM;
    logic               w_mcStart;

    forward_unit u_forwardUnit (
        .i_rs1E      (bus.Rs1E),
        .i_rs2E      (bus.Rs2E),
        .i_rdM       (bus.RdM),
        .i_rdW       (bus.RdW),
        .i_regWriteM (bus.RegWriteM),
        .i_regWriteW (bus.RegWriteW),
        .o_forwardAE (w_fwdA),
        .o_forwardBE (w_fwdB)
    );

    // A load in execute whose destination is read by decode cannot be forwarded in time.
    assign w_lduse = (bus.ResultSrcE == RESULTSRC_LOAD) &&
                     (regMatch(bus.Rs1D, bus.RdE) || regMatch(bus.Rs2D, bus.RdE));

    assign w_timerExpired = (r_timer == TIMER_W'(MC_TIMEOUT - 1));

    // A result arriving on the last allowed cycle still counts, so done masks the timeout.
    assign w_abandon = (r_state == HC_MC_WAIT) && !bus.mc_done && w_timerExpired;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HC_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection; a branch in RUN cancels the op before it starts.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            HC_RUN: begin
                if (!bus.PCSrcE && bus.McOpE) begin
                    w_nextState = HC_MC_WAIT;
                end
            end
            HC_MC_WAIT: begin
                if (bus.mc_done) begin
                    w_nextState = HC_MC_DRAIN;
                end else if (w_timerExpired) begin
                    w_nextState = HC_RUN;
                end
            end
            HC_MC_DRAIN: begin
                w_nextState = HC_RUN;
            end
            default: begin
                w_nextState = HC_RUN;
            end
        endcase
    end

    // Stall/flush enables per state; while waiting, branch and load-use are frozen behind the op.
    always_comb begin
        w_stallF  = 1'b0;
        w_stallD  = 1'b0;
        w_stallE  = 1'b0;
        w_flushD  = 1'b0;
        w_flushE  = 1'b0;
        w_flushM  = 1'b0;
        w_mcStart = 1'b0;
        case (r_state)
            HC_RUN: begin
                if (bus.PCSrcE) begin
                    w_flushD = 1'b1;
                    w_flushE = 1'b1;
                end else if (bus.McOpE) begin
                    w_mcStart = 1'b1;
                    w_stallF  = 1'b1;
                    w_stallD  = 1'b1;
                    w_stallE  = 1'b1;
                    w_flushM  = 1'b1;
                end else if (w_lduse) begin
                    w_stallF = 1'b1;
                    w_stallD = 1'b1;
                    w_flushE = 1'b1;
                end
            end
            HC_MC_WAIT: begin
                w_stallF = 1'b1;
                w_stallD = 1'b1;
                w_stallE = 1'b1;
                w_flushM = 1'b1;
                if (w_abandon) begin
                    w_flushE = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Cycle count inside MC_WAIT; restarts from zero every time the state is entered.
    always_ff @(posedge clk) begin
        if (rst || (r_state != HC_MC_WAIT)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TIMER_W'(1);
        end
    end

    // Sticky error flag for an abandoned multi-cycle op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcError <= 1'b0;
        end else if (w_abandon) begin
            r_mcError <= 1'b1;
        end
    end

    // Saturating performance counters for stalled fetch cycles and flushed cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stallF && (r_stallCnt != {CNT_W{1'b1}})) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if ((w_flushD || w_flushE || w_flushM) && (r_flushCnt != {CNT_W{1'b1}})) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
        end
    end

    assign bus.ForwardAE = w_fwdA;
    assign bus.ForwardBE = w_fwdB;
    assign bus.StallF    = w_stallF;
    assign bus.StallD    = w_stallD;
    assign bus.StallE    = w_stallE;
    assign bus.FlushD    = w_flushD;
    assign bus.FlushE    = w_flushE;
    assign bus.FlushM    = w_flushM;
    assign bus.mc_start  = w_mcStart;
    assign bus.mc_error  = r_mcError;
    assign bus.stall_cnt = r_stallCnt;
    assign bus.flush_cnt = r_flushCnt;

endmodule
